// File: rtl/xc_malu_wb_seq.sv
// xc_malu_wb_seq: writeback sequencer behind the multi-cycle MALU.
// It captures one 64-bit MALU result and retires the op by pulsing malu_flush.
// It then emits one or two 32-bit register writes over a valid/ready port.
// Optional build macro XC_MALU_WB_ZERO_SKIP_EN: beats addressed to x0 are never
// presented. Each such beat is consumed internally in a single cycle.
module xc_malu_wb_seq #(
  parameter int RD_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            malu_valid,
  input  logic            malu_ready,
  input  logic [63:0]     malu_result,
  output logic            malu_flush,
  input  logic [RD_W-1:0] op_rd,
  input  logic            op_hi,
  input  logic            op_pair,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_addr,
  output logic [31:0]     wb_data,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_res_hi;   // upper result word, needed only for BEAT1 of a pair
  logic [RD_W-2:0] r_rd_hi;    // register-pair base (rd without bit 0)
  logic            r_pair;
  logic [RD_W-1:0] r_wb_addr;
  logic [31:0]     r_wb_data;

  logic            w_busy;
  logic            w_skip;
  logic            w_consume;
  logic            w_final;
  logic            w_take;
  logic [RD_W-1:0] w_cap_addr;
  logic [31:0]     w_cap_data;

  assign w_busy = (r_state != IDLE);

`ifdef XC_MALU_WB_ZERO_SKIP_EN
  // A beat targeting x0 is dropped in place of being presented.
  assign w_skip = w_busy && (r_wb_addr == '0);
`else
  assign w_skip = 1'b0;
`endif

  // The current beat leaves the buffer when it is accepted or when it is skipped.
  assign w_consume = w_busy && (w_skip || wb_ready);
  assign w_final   = (r_state == BEAT1) || ((r_state == BEAT0) && !r_pair);
  // A new result can enter when the buffer is empty, or when it is draining its final beat this cycle.
  assign w_take    = !reset && malu_valid && malu_ready && (!w_busy || (w_consume && w_final));

  assign malu_flush = w_take;
  assign wb_valid   = w_busy && !w_skip;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign busy       = w_busy;

  // First-beat address/data for the incoming op; pair takes priority over hi.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_cap_addr = op_rd;
    w_cap_data = malu_result[31:0];
    if (op_pair) begin
      w_cap_addr = {op_rd[RD_W-1:1], 1'b0};
    end else if (op_hi) begin
      w_cap_data = malu_result[63:32];
    end
  end

  // Sequencer FSM with registered beat address/data.
  // NOTE: state is updated only with non-blocking assignments, so every reader sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_res_hi  <= '0;
      r_rd_hi   <= '0;
      r_pair    <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (w_take) begin
      r_state   <= BEAT0;
      r_res_hi  <= malu_result[63:32];
      r_rd_hi   <= op_rd[RD_W-1:1];
      r_pair    <= op_pair;
      r_wb_addr <= w_cap_addr;
      r_wb_data <= w_cap_data;
    end else if (w_consume) begin
      if ((r_state == BEAT0) && r_pair) begin
        r_state   <= BEAT1;
        r_wb_addr <= {r_rd_hi, 1'b1};
        r_wb_data <= r_res_hi;
      end else begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_xc_malu_wb_seq.sv
// Bench for xc_malu_wb_seq: directed scenarios plus a randomized MALU/writeback
// stream, checked every cycle against a queue-of-beats reference model.
module tb_xc_malu_wb_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        malu_valid = 1'b0;
  logic        malu_ready = 1'b0;
  logic [63:0] malu_result = '0;
  logic        malu_flush;
  logic [4:0]  op_rd = '0;
  logic        op_hi = 1'b0;
  logic        op_pair = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;

  xc_malu_wb_seq #(.RD_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .malu_valid  (malu_valid),
    .malu_ready  (malu_ready),
    .malu_result (malu_result),
    .malu_flush  (malu_flush),
    .op_rd       (op_rd),
    .op_hi       (op_hi),
    .op_pair     (op_pair),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];          // beats still owed by the DUT, oldest first
  int    checks = 0;
  int    errors = 0;

  // Last sampled DUT outputs, for explicit scenario checks.
  logic        obs_valid, obs_busy;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the beats a captured op must produce, straight from the write rules.
  task automatic push_op(input logic [63:0] res, input logic [4:0] rd, input logic hi, input logic pair);
    beat_t b;
    if (pair) begin
      b.addr = rd & 5'h1E;
      b.data = res[31:0];
      q.push_back(b);
      b.addr = rd | 5'h01;
      b.data = res[63:32];
      q.push_back(b);
    end else begin
      b.addr = rd;
      b.data = hi ? res[63:32] : res[31:0];
      q.push_back(b);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input logic v, input logic r, input logic [63:0] res, input logic [4:0] rd,
                      input logic hi, input logic pair, input logic wr, output logic flushed);
    logic exp_busy, exp_valid, skip, consume, exp_flush;
    @(negedge clock);
    malu_valid  = v;
    malu_ready  = r;
    malu_result = res;
    op_rd       = rd;
    op_hi       = hi;
    op_pair     = pair;
    wb_ready    = wr;
    #1;
    exp_busy = (q.size() != 0);
    skip = 1'b0;
`ifdef XC_MALU_WB_ZERO_SKIP_EN
    if (exp_busy) skip = (q[0].addr == 5'd0);
`endif
    exp_valid = exp_busy && !skip;
    check("busy", {63'd0, busy}, {63'd0, exp_busy});
    check("wb_valid", {63'd0, wb_valid}, {63'd0, exp_valid});
    if (exp_valid) begin
      check("wb_addr", {59'd0, wb_addr}, {59'd0, q[0].addr});
      check("wb_data", {32'd0, wb_data}, {32'd0, q[0].data});
    end
    consume   = exp_busy && (wr || skip);
    exp_flush = v && r && (!exp_busy || (consume && q.size() == 1));
    check("malu_flush", {63'd0, malu_flush}, {63'd0, exp_flush});
    obs_valid = wb_valid;
    obs_busy  = busy;
    obs_addr  = wb_addr;
    obs_data  = wb_data;
    flushed   = exp_flush;
    if (consume) void'(q.pop_front());
    if (exp_flush) push_op(res, rd, hi, pair);
  endtask

  // Assert reset for one edge with a ready MALU op on the inputs; flush must stay low.
  task automatic reset_cycle();
    @(negedge clock);
    reset       = 1'b1;
    malu_valid  = 1'b1;
    malu_ready  = 1'b1;
    malu_result = 64'hDEADBEEF_CAFEF00D;
    op_rd       = 5'd3;
    wb_ready    = 1'b1;
    #1;
    check("flush_in_reset", {63'd0, malu_flush}, 64'd0);
    @(negedge clock);
    reset      = 1'b0;
    malu_valid = 1'b0;
    malu_ready = 1'b0;
    wb_ready   = 1'b0;
    q.delete();
  endtask

  initial begin
    logic        f;
    logic        have_op, rdy;
    logic [63:0] c_res;
    logic [4:0]  c_rd;
    logic        c_hi, c_pair;

    // Power-on reset, with the MALU presenting a ready op.
    malu_valid = 1'b1;
    malu_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_flush", {63'd0, malu_flush}, 64'd0);
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
    check("rst_wb_data", {32'd0, wb_data}, 64'd0);
    malu_valid = 1'b0;
    malu_ready = 1'b0;
    reset = 1'b0;

    // Single lo write.
    step(1, 1, 64'h11112222_33334444, 5'd5, 0, 0, 1, f);
    check("lo_flush", {63'd0, f}, 64'd1);
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("lo_valid", {63'd0, obs_valid}, 64'd1);
    check("lo_addr", {59'd0, obs_addr}, 64'd5);
    check("lo_data", {32'd0, obs_data}, 64'h33334444);
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("lo_idle", {63'd0, obs_busy}, 64'd0);

    // Pair write with stalled writeback.
    step(1, 1, 64'hAAAAAAAA_55555555, 5'd7, 0, 1, 0, f);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0, 0, 0, 0, f);
      check("pair_hold_addr", {59'd0, obs_addr}, 64'd6);
    end
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("pair_lo_data", {32'd0, obs_data}, 64'h55555555);
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("pair_hi_addr", {59'd0, obs_addr}, 64'd7);
    check("pair_hi_data", {32'd0, obs_data}, 64'hAAAAAAAA);
    step(0, 0, '0, '0, 0, 0, 1, f);

    // Back-pressure: second result waits for the BEAT1 handshake.
    step(1, 1, 64'h01234567_89ABCDEF, 5'd9, 0, 1, 1, f);
    step(0, 0, '0, '0, 0, 0, 1, f);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 64'hFEDCBA98_76543210, 5'd20, 1, 0, 0, f);
      check("bp_no_flush", {63'd0, f}, 64'd0);
    end
    step(1, 1, 64'hFEDCBA98_76543210, 5'd20, 1, 0, 1, f);
    check("bp_flush", {63'd0, f}, 64'd1);
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("bp_new_addr", {59'd0, obs_addr}, 64'd20);
    check("bp_new_data", {32'd0, obs_data}, 64'hFEDCBA98);
    step(0, 0, '0, '0, 0, 0, 1, f);

    // Zero-bubble stream of four single writes.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, {32'h1000 + i, 32'h2000 + i}, 5'(10 + i), i[0], 0, 1, f);
      check("zb_flush", {63'd0, f}, 64'd1);
      if (i > 0) check("zb_addr", {59'd0, obs_addr}, 64'(10 + i - 1));
    end
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("zb_last_addr", {59'd0, obs_addr}, 64'd13);
    step(0, 0, '0, '0, 0, 0, 1, f);

    // Reset mid-pair: the hi beat is dropped.
    step(1, 1, 64'h77777777_66666666, 5'd12, 0, 1, 1, f);
    step(0, 0, '0, '0, 0, 0, 1, f);
    step(0, 0, '0, '0, 0, 0, 0, f);
    check("rmp_in_beat1", {59'd0, obs_addr}, 64'd13);
    reset_cycle();
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("rmp_busy", {63'd0, obs_busy}, 64'd0);
    check("rmp_valid", {63'd0, obs_valid}, 64'd0);
    step(0, 0, '0, '0, 0, 0, 1, f);

    // Write to x0, and a pair at x0/x1.
    step(1, 1, 64'hCCCCCCCC_33333333, 5'd0, 1, 0, 1, f);
    step(0, 0, '0, '0, 0, 0, 1, f);
`ifdef XC_MALU_WB_ZERO_SKIP_EN
    check("zs_no_valid", {63'd0, obs_valid}, 64'd0);
    check("zs_busy", {63'd0, obs_busy}, 64'd1);
`else
    check("zs_valid", {63'd0, obs_valid}, 64'd1);
    check("zs_addr", {59'd0, obs_addr}, 64'd0);
    check("zs_data", {32'd0, obs_data}, 64'hCCCCCCCC);
`endif
    step(0, 0, '0, '0, 0, 0, 1, f);
    check("zs_idle", {63'd0, obs_busy}, 64'd0);
    step(1, 1, 64'hBBBBBBBB_44444444, 5'd1, 0, 1, 1, f);
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 0, 1, f);

    // Randomized stream against the model.
    have_op = 1'b0;
    rdy     = 1'b0;
    c_res   = '0;
    c_rd    = '0;
    c_hi    = 1'b0;
    c_pair  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!have_op && $urandom_range(0, 3) != 0) begin
        have_op = 1'b1;
        rdy     = 1'b0;
        c_res   = {$urandom, $urandom};
        c_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31));
        c_hi    = 1'($urandom_range(0, 1));
        c_pair  = 1'($urandom_range(0, 1));
      end
      if (have_op && !rdy) rdy = ($urandom_range(0, 2) == 0);
      step(have_op, rdy, c_res, c_rd, c_hi, c_pair, ($urandom_range(0, 3) != 0), f);
      if (f) begin
        have_op = 1'b0;
        rdy     = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, 0, 1, f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
